// File: rtl/fs_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FS_OVF_EN macro adds a signed-overflow flag (see fs_serial_sub).
package fs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fs_state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/fs_serial_sub_if.sv
// Handshake/operand bundle between a controller and fs_serial_sub.
// Defining FS_OVF_EN adds the ov result flag to the bundle.
interface fs_serial_sub_if
    import fs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef FS_OVF_EN
    logic             ov;

    modport master (output start, a, b, bi, input busy, done, d, bo, ov);
    modport slave  (input start, a, b, bi, output busy, done, d, bo, ov);
`else
    modport master (output start, a, b, bi, input busy, done, d, bo);
    modport slave  (input start, a, b, bi, output busy, done, d, bo);
`endif

endinterface

// File: rtl/fs_bit.sv
// Combinational one-bit full subtractor: d = a - b - bi with borrow out.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/fs_serial_sub.sv
// Bit-serial subtractor: d = a - b - bi, LSB first, one bit per clock through one fs_bit.
// Optional macro FS_OVF_EN adds a registered signed-overflow output ov.
module fs_serial_sub
    import fs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    fs_serial_sub_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    fs_state_e        state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-2:0] r_sh_r;
    logic [WIDTH-1:0] d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             br_r;
    logic             bo_r;
    logic             busy_r;
    logic             done_r;
    logic             diff_s;
    logic             bout_s;
    logic             last_s;
    logic [WIDTH-1:0] res_s;
`ifdef FS_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ov_r;
`endif

    fs_bit u_bit (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .bi (br_r),
        .d  (diff_s),
        .bo (bout_s)
    );

    // r_sh_r keeps only the bits that survive the next shift; res_s is the full shifted word
    assign res_s  = {diff_s, r_sh_r};
    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Control FSM and serial datapath; results update only on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            r_sh_r  <= {(WIDTH-1){1'b0}};
            d_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            br_r    <= 1'b0;
            bo_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef FS_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ov_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        br_r    <= bus.bi;
                        r_sh_r  <= {(WIDTH-1){1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef FS_OVF_EN
                        a_msb_r <= bus.a[WIDTH-1];
                        b_msb_r <= bus.b[WIDTH-1];
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    br_r   <= bout_s;
                    r_sh_r <= res_s[WIDTH-1:1];
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        d_r     <= res_s;
                        bo_r    <= bout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
`ifdef FS_OVF_EN
                        // Result MSB is the bit being produced now
                        ov_r    <= (a_msb_r != b_msb_r) && (diff_s != a_msb_r);
`endif
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bo   = bo_r;
`ifdef FS_OVF_EN
    assign bus.ov   = ov_r;
`endif

endmodule

// File: doc/fs_serial_sub.md
Name: fs_serial_sub

Overview:
Bit-serial, multi-cycle subtractor. It computes d = a - b - bi with borrow-out, LSB first, one bit per clock.
It is the inverse-direction companion to the team's full-adder / 4-bit ripple-adder blocks.
It trades area for latency, so it uses one full-subtractor cell instead of WIDTH cells.
A start/busy/done handshake lets a controller issue operations back-to-back.

Parameters:
WIDTH, 4, operand and result width in bits (>=2)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bi  input  1  borrow in, captured when start is accepted
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; d/bo valid from this cycle
d  output  WIDTH  difference, registered, held until next completion
bo  output  1  borrow out, registered, held until next completion

Behaviour:
- Reset is asynchronous: clk and rst as stated; asynchronous active-high rst.
- Reset state: state=IDLE; busy=0, done=0, d=0, bo=0; all shift registers and counter = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load a_sh=a, b_sh=b, br=bi, cnt=0, go to RUN.
  - RUN: on each edge, process bit 0 of a_sh/b_sh with br.
    - diff = a0 ^ b0 ^ br
    - br <= (~a0 & b0) | (~(a0 ^ b0) & br)
    - a_sh, b_sh shift right; r_sh <= {diff, r_sh[WIDTH-1:1]}; cnt++.
  - RUN exit: on the edge where cnt == WIDTH-1, go to DONE.
    - On that same edge: d <= {diff, r_sh[WIDTH-1:1]}, bo <= final borrow.
  - DONE: done=1 for exactly this one cycle, then IDLE.
    - If start=1 while in DONE, load new operands and go directly to RUN (back-to-back, no idle bubble).
- Latency: done asserts WIDTH edges after the edge that accepts start (4 cycles at WIDTH=4). Throughput is one op per WIDTH+1 cycles.
- start in RUN is ignored. Operands are captured only at acceptance, so changing a/b/bi during RUN has no effect.
- d and bo never change during RUN; they change only on the edge entering DONE.
- Arithmetic is modulo 2^WIDTH. bo=1 exactly when a < b + bi as unsigned values.
- rst asserted mid-RUN: immediate return to reset state; the partial result is discarded and done does not pulse.
- Counter cnt width is $clog2(WIDTH).

Optional Feature:
FS_OVF_EN
- Defined: adds output port ov (1 bit), registered alongside d/bo, reset 0.
  - ov = signed two's-complement overflow of a - b - bi: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).
  - Operand MSBs are held in capture registers for this.
- Undefined: ov port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package fs_pkg holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - default WIDTH constant
- One sub-module, fs_bit: combinational full subtractor (inputs a, b, bi; outputs d, bo). It is instantiated once in the serial datapath.

Test Plan:
1. a=9, b=3, bi=0, start pulse -> done 4 cycles later; d=4'd6, bo=0; busy high during exactly 4 cycles.
2. a=3, b=9, bi=0 -> d=4'hA, bo=1. Then a=0, b=0, bi=1 -> d=4'hF, bo=1.
3. Hold start=1 through RUN with a/b changing -> result matches first operands only. Next op (a=15, b=1) accepted in the DONE cycle -> next done 5 cycles after the prior done; d=4'hE, bo=0.
4. Assert rst on 2nd RUN cycle -> busy, done, d, bo = 0 within the same cycle (asynchronous). A later op a=5, b=2 -> d=3, bo=0.
5. Random sweep over all 512 (a, b, bi) combinations at WIDTH=4, plus 200 random ops at WIDTH=8 -> {bo, d} equals the model (a - b - bi) mod 2^(WIDTH+1).
6. With FS_OVF_EN: a=7, b=15, bi=0 -> d=8, bo=1, ov=1. With a=5, b=3 -> d=2, ov=0.
